// File: rtl/pe_pass_ctrl_if.sv
// PE-side link of the pass controller: config strobe plus the four valid/ready streams.
// The controller drives through the master modport and the PE sits on the slave modport.
interface pe_pass_ctrl_if #(
    parameter int DATA_BITS   = 32,
    parameter int CONFIG_SIZE = 9
);
    logic                   PE_en;
    logic [CONFIG_SIZE-1:0] i_config;
    logic [DATA_BITS-1:0]   filter;
    logic                   filter_valid;
    logic                   filter_ready;
    logic [DATA_BITS-1:0]   ifmap;
    logic                   ifmap_valid;
    logic                   ifmap_ready;
    logic [DATA_BITS-1:0]   ipsum;
    logic                   ipsum_valid;
    logic                   ipsum_ready;
    logic [DATA_BITS-1:0]   opsum;
    logic                   opsum_valid;
    logic                   opsum_ready;

    modport master (
        output PE_en, i_config,
        output filter, filter_valid, ifmap, ifmap_valid, ipsum, ipsum_valid, opsum_ready,
        input  filter_ready, ifmap_ready, ipsum_ready, opsum, opsum_valid
    );

    modport slave (
        input  PE_en, i_config,
        input  filter, filter_valid, ifmap, ifmap_valid, ipsum, ipsum_valid, opsum_ready,
        output filter_ready, ifmap_ready, ipsum_ready, opsum, opsum_valid
    );
endinterface

// File: rtl/pe_pass_ctrl.sv
// Runs one full PE pass: config, filter rows, then F+1 rounds of ifmap/ipsum/opsum.
// Each phase's valid depends only on the state; data and addresses come straight from the counters and RF.
module pe_pass_ctrl #(
    parameter int DATA_BITS   = 32,
    parameter int CONFIG_SIZE = 9,
    parameter int AW          = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           cfg_p,
    input  logic [4:0]           cfg_F,
    input  logic [1:0]           cfg_q,
    input  logic                 ipsum_en,
    output logic                 busy,
    output logic                 done,
    output logic [AW-1:0]        filt_addr,
    input  logic [DATA_BITS-1:0] filt_rdata,
    output logic [AW-1:0]        ifmap_addr,
    input  logic [DATA_BITS-1:0] ifmap_rdata,
    output logic [AW-1:0]        ipsum_addr,
    input  logic [DATA_BITS-1:0] ipsum_rdata,
    output logic [AW-1:0]        opsum_addr,
    output logic [DATA_BITS-1:0] opsum_wdata,
    output logic                 opsum_we,
    pe_pass_ctrl_if.master       pe
);

    typedef enum logic [2:0] {
        S_IDLE, S_CONFIG, S_FILTER, S_IFMAP, S_IPSUM, S_OPSUM, S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] p_q, p_d, q_q, q_d;
    logic [4:0] f_q, f_d;
    logic       ipsum_en_q, ipsum_en_d;
    logic [3:0] k_q, k_d;
    logic [5:0] ifm_q, ifm_d;
    logic [4:0] it_q, it_d;
    logic [1:0] w_q, w_d;
    logic [1:0] j_q, j_d;

    logic       filt_last;
    logic       ifm_last;
    logic [6:0] pass_addr;

    // The first iteration primes the 3-wide window; later ones slide it by one word.
    assign filt_last = (k_q == (4'd3 * {2'b00, p_q} + 4'd2));
    assign ifm_last  = (it_q == 5'd0) ? (w_q == 2'd2) : 1'b1;
    assign pass_addr = 7'(it_q) * (7'(p_q) + 7'd1) + 7'(j_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            p_q        <= '0;
            f_q        <= '0;
            q_q        <= '0;
            ipsum_en_q <= 1'b0;
            k_q        <= '0;
            ifm_q      <= '0;
            it_q       <= '0;
            w_q        <= '0;
            j_q        <= '0;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            f_q        <= f_d;
            q_q        <= q_d;
            ipsum_en_q <= ipsum_en_d;
            k_q        <= k_d;
            ifm_q      <= ifm_d;
            it_q       <= it_d;
            w_q        <= w_d;
            j_q        <= j_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        p_d        = p_q;
        f_d        = f_q;
        q_d        = q_q;
        ipsum_en_d = ipsum_en_q;
        k_d        = k_q;
        ifm_d      = ifm_q;
        it_d       = it_q;
        w_d        = w_q;
        j_d        = j_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    p_d        = cfg_p;
                    f_d        = cfg_F;
                    q_d        = cfg_q;
                    ipsum_en_d = ipsum_en;
                    k_d        = '0;
                    ifm_d      = '0;
                    it_d       = '0;
                    w_d        = '0;
                    j_d        = '0;
                    state_d    = S_CONFIG;
                end
            end
            S_CONFIG: state_d = S_FILTER;
            S_FILTER: begin
                if (pe.filter_ready) begin
                    if (filt_last) begin
                        k_d     = '0;
                        it_d    = '0;
                        w_d     = '0;
                        state_d = S_IFMAP;
                    end else begin
                        k_d = k_q + 4'd1;
                    end
                end
            end
            S_IFMAP: begin
                if (pe.ifmap_ready) begin
                    ifm_d = ifm_q + 6'd1;
                    if (ifm_last) begin
                        w_d     = '0;
                        j_d     = '0;
                        state_d = S_IPSUM;
                    end else begin
                        w_d = w_q + 2'd1;
                    end
                end
            end
            S_IPSUM: begin
                if (pe.ipsum_ready) begin
                    if (j_q == p_q) begin
                        j_d     = '0;
                        state_d = S_OPSUM;
                    end else begin
                        j_d = j_q + 2'd1;
                    end
                end
            end
            S_OPSUM: begin
                if (pe.opsum_valid) begin
                    if (j_q == p_q) begin
                        j_d = '0;
                        if (it_q == f_q) begin
                            state_d = S_DONE;
                        end else begin
                            it_d    = it_q + 5'd1;
                            state_d = S_IFMAP;
                        end
                    end else begin
                        j_d = j_q + 2'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy             = (state_q != S_IDLE);
        done             = (state_q == S_DONE);
        pe.PE_en         = (state_q == S_CONFIG);
        pe.i_config      = busy ? CONFIG_SIZE'({p_q, f_q, q_q}) : '0;
        pe.filter_valid  = (state_q == S_FILTER);
        pe.ifmap_valid   = (state_q == S_IFMAP);
        pe.ipsum_valid   = (state_q == S_IPSUM);
        pe.opsum_ready   = (state_q == S_OPSUM);
        filt_addr        = pe.filter_valid ? AW'(k_q) : '0;
        pe.filter        = pe.filter_valid ? filt_rdata : '0;
        ifmap_addr       = pe.ifmap_valid ? AW'(ifm_q) : '0;
        pe.ifmap         = pe.ifmap_valid ? ifmap_rdata : '0;
        ipsum_addr       = pe.ipsum_valid ? AW'(pass_addr) : '0;
        pe.ipsum         = (pe.ipsum_valid && ipsum_en_q) ? ipsum_rdata : '0;
        opsum_addr       = pe.opsum_ready ? AW'(pass_addr) : '0;
        opsum_wdata      = pe.opsum_ready ? pe.opsum : '0;
        opsum_we         = pe.opsum_ready && pe.opsum_valid;
    end

endmodule

// File: tb/tb_pe_pass_ctrl.sv
// Self-checking bench for pe_pass_ctrl: behavioural PE and register files, scoreboarded transfers.
module tb_pe_pass_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  cfg_p;
    logic [4:0]  cfg_F;
    logic [1:0]  cfg_q;
    logic        ipsum_en;
    logic        busy;
    logic        done;
    logic [7:0]  filt_addr;
    logic [31:0] filt_rdata;
    logic [7:0]  ifmap_addr;
    logic [31:0] ifmap_rdata;
    logic [7:0]  ipsum_addr;
    logic [31:0] ipsum_rdata;
    logic [7:0]  opsum_addr;
    logic [31:0] opsum_wdata;
    logic        opsum_we;

    pe_pass_ctrl_if #(.DATA_BITS(32), .CONFIG_SIZE(9)) pe_if ();

    pe_pass_ctrl #(.DATA_BITS(32), .CONFIG_SIZE(9), .AW(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_p(cfg_p), .cfg_F(cfg_F), .cfg_q(cfg_q), .ipsum_en(ipsum_en),
        .busy(busy), .done(done),
        .filt_addr(filt_addr), .filt_rdata(filt_rdata),
        .ifmap_addr(ifmap_addr), .ifmap_rdata(ifmap_rdata),
        .ipsum_addr(ipsum_addr), .ipsum_rdata(ipsum_rdata),
        .opsum_addr(opsum_addr), .opsum_wdata(opsum_wdata), .opsum_we(opsum_we),
        .pe(pe_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] filt_rf  [256];
    logic [31:0] ifmap_rf [256];
    logic [31:0] ipsum_rf [256];
    logic [31:0] opsum_rf [256];

    assign filt_rdata  = filt_rf[filt_addr];
    assign ifmap_rdata = ifmap_rf[ifmap_addr];
    assign ipsum_rdata = ipsum_rf[ipsum_addr];

    int tests_run    = 0;
    int tests_failed = 0;
    int done_cnt     = 0;
    int busy_cycles  = 0;
    bit stall_en     = 1'b0;
    logic [8:0] exp_cfg = '0;

    int          exp_filt[$];
    int          exp_ifm[$];
    int          exp_ips_addr[$];
    logic [31:0] exp_ips_data[$];
    int          exp_op_addr[$];
    logic [31:0] exp_op_data[$];

    // Behavioural PE: keeps filter rows, a 3-word ifmap window and the ipsums, then answers with ipsum + dot.
    logic        fr_q, ir_q, pr_q, ov_q;
    logic [1:0]  m_p;
    logic [31:0] m_filt [16];
    logic [31:0] m_win  [3];
    logic [31:0] m_ips  [4];
    logic [3:0]  m_fcnt;
    logic [2:0]  m_ipcnt;
    logic [1:0]  m_ocnt;
    logic        m_out;
    logic [3:0]  m_base;
    logic [31:0] m_opsum;

    assign pe_if.filter_ready = fr_q;
    assign pe_if.ifmap_ready  = ir_q;
    assign pe_if.ipsum_ready  = pr_q;
    assign pe_if.opsum_valid  = m_out && ov_q;
    assign pe_if.opsum        = m_opsum;

    always_comb begin
        m_base  = {2'b00, m_ocnt} * 4'd3;
        m_opsum = m_ips[m_ocnt] + m_filt[m_base] * m_win[0]
                + m_filt[m_base + 4'd1] * m_win[1] + m_filt[m_base + 4'd2] * m_win[2];
    end

    always @(posedge clk) begin
        if (!rst) begin
            fr_q <= 1'b0; ir_q <= 1'b0; pr_q <= 1'b0; ov_q <= 1'b0;
            m_p <= '0; m_fcnt <= '0; m_ipcnt <= '0; m_ocnt <= '0; m_out <= 1'b0;
            m_win[0] <= '0; m_win[1] <= '0; m_win[2] <= '0;
        end else begin
            fr_q <= stall_en ? ($urandom_range(0, 9) < 6) : 1'b1;
            ir_q <= stall_en ? ($urandom_range(0, 9) < 6) : 1'b1;
            pr_q <= stall_en ? ($urandom_range(0, 9) < 5) : 1'b1;
            ov_q <= stall_en ? ($urandom_range(0, 9) < 6) : 1'b1;
            if (pe_if.PE_en) begin
                m_p     <= pe_if.i_config[8:7];
                m_fcnt  <= '0;
                m_ipcnt <= '0;
                m_ocnt  <= '0;
                m_out   <= 1'b0;
            end
            if (pe_if.filter_valid && pe_if.filter_ready) begin
                m_filt[m_fcnt] <= pe_if.filter;
                m_fcnt         <= m_fcnt + 4'd1;
            end
            if (pe_if.ifmap_valid && pe_if.ifmap_ready) begin
                m_win[0] <= m_win[1];
                m_win[1] <= m_win[2];
                m_win[2] <= pe_if.ifmap;
            end
            if (pe_if.ipsum_valid && pe_if.ipsum_ready) begin
                m_ips[m_ipcnt[1:0]] <= pe_if.ipsum;
                m_ipcnt             <= m_ipcnt + 3'd1;
                if (m_ipcnt[1:0] == m_p) m_out <= 1'b1;
            end
            if (pe_if.opsum_valid && pe_if.opsum_ready) begin
                if (m_ocnt == m_p) begin
                    m_out   <= 1'b0;
                    m_ocnt  <= '0;
                    m_ipcnt <= '0;
                end else begin
                    m_ocnt <= m_ocnt + 2'd1;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every transfer, checks stall stability, and performs the opsum RF write.
    bit          fs_prev = 0, is_prev = 0, ps_prev = 0;
    logic [7:0]  fa_prev, ia_prev, pa_prev;
    logic [31:0] fd_prev, id_prev, pd_prev;
    initial begin
        int e;
        logic [31:0] d;
        forever begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) done_cnt++;
            if (pe_if.PE_en || done) begin
                tests_run++;
                if (pe_if.i_config !== exp_cfg) begin
                    tests_failed++;
                    $display("[TB] FAIL i_config got=%h want=%h", pe_if.i_config, exp_cfg);
                end
            end
            if (pe_if.filter_valid && fs_prev) begin
                tests_run++;
                if (filt_addr !== fa_prev || pe_if.filter !== fd_prev) begin
                    tests_failed++;
                    $display("[TB] FAIL filt_stall got=%0d/%h want=%0d/%h", filt_addr, pe_if.filter, fa_prev, fd_prev);
                end
            end
            fs_prev = pe_if.filter_valid && !pe_if.filter_ready;
            fa_prev = filt_addr; fd_prev = pe_if.filter;
            if (pe_if.ifmap_valid && is_prev) begin
                tests_run++;
                if (ifmap_addr !== ia_prev || pe_if.ifmap !== id_prev) begin
                    tests_failed++;
                    $display("[TB] FAIL ifmap_stall got=%0d/%h want=%0d/%h", ifmap_addr, pe_if.ifmap, ia_prev, id_prev);
                end
            end
            is_prev = pe_if.ifmap_valid && !pe_if.ifmap_ready;
            ia_prev = ifmap_addr; id_prev = pe_if.ifmap;
            if (pe_if.ipsum_valid && ps_prev) begin
                tests_run++;
                if (ipsum_addr !== pa_prev || pe_if.ipsum !== pd_prev) begin
                    tests_failed++;
                    $display("[TB] FAIL ipsum_stall got=%0d/%h want=%0d/%h", ipsum_addr, pe_if.ipsum, pa_prev, pd_prev);
                end
            end
            ps_prev = pe_if.ipsum_valid && !pe_if.ipsum_ready;
            pa_prev = ipsum_addr; pd_prev = pe_if.ipsum;
            if (pe_if.filter_valid && pe_if.filter_ready) begin
                tests_run++;
                if (exp_filt.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL filt_read unexpected addr=%0d want=none", filt_addr);
                end else begin
                    e = exp_filt.pop_front();
                    if (filt_addr !== 8'(e) || pe_if.filter !== filt_rf[8'(e)]) begin
                        tests_failed++;
                        $display("[TB] FAIL filt_read got=%0d/%h want=%0d/%h", filt_addr, pe_if.filter, e, filt_rf[8'(e)]);
                    end
                end
            end
            if (pe_if.ifmap_valid && pe_if.ifmap_ready) begin
                tests_run++;
                if (exp_ifm.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL ifmap_read unexpected addr=%0d want=none", ifmap_addr);
                end else begin
                    e = exp_ifm.pop_front();
                    if (ifmap_addr !== 8'(e) || pe_if.ifmap !== ifmap_rf[8'(e)]) begin
                        tests_failed++;
                        $display("[TB] FAIL ifmap_read got=%0d/%h want=%0d/%h", ifmap_addr, pe_if.ifmap, e, ifmap_rf[8'(e)]);
                    end
                end
            end
            if (pe_if.ipsum_valid && pe_if.ipsum_ready) begin
                tests_run++;
                if (exp_ips_addr.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL ipsum_read unexpected addr=%0d want=none", ipsum_addr);
                end else begin
                    e = exp_ips_addr.pop_front();
                    d = exp_ips_data.pop_front();
                    if (ipsum_addr !== 8'(e) || pe_if.ipsum !== d) begin
                        tests_failed++;
                        $display("[TB] FAIL ipsum_read got=%0d/%h want=%0d/%h", ipsum_addr, pe_if.ipsum, e, d);
                    end
                end
            end
            if (opsum_we) begin
                tests_run++;
                if (exp_op_addr.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL opsum_write unexpected addr=%0d want=none", opsum_addr);
                end else begin
                    e = exp_op_addr.pop_front();
                    d = exp_op_data.pop_front();
                    if (opsum_addr !== 8'(e) || opsum_wdata !== d) begin
                        tests_failed++;
                        $display("[TB] FAIL opsum_write got=%0d/%h want=%0d/%h", opsum_addr, opsum_wdata, e, d);
                    end
                end
                opsum_rf[opsum_addr] = opsum_wdata;
            end
        end
    end

    task automatic load_rfs();
        for (int i = 0; i < 256; i++) begin
            filt_rf[i]  = $urandom;
            ifmap_rf[i] = $urandom;
            ipsum_rf[i] = $urandom;
            opsum_rf[i] = 32'hDEADBEEF;
        end
    endtask

    function automatic logic [31:0] golden(int p, int it, int j, bit en);
        int a = (it * (p + 1) + j) % 256;
        logic [31:0] v = en ? ipsum_rf[a] : 32'd0;
        for (int r = 0; r < 3; r++) v = v + filt_rf[j * 3 + r] * ifmap_rf[it + r];
        return v;
    endfunction

    task automatic push_expect(int p, int f, int q, bit en);
        exp_cfg = {2'(p), 5'(f), 2'(q)};
        for (int k = 0; k < 3 * (p + 1); k++) exp_filt.push_back(k);
        for (int i = 0; i < f + 3; i++) exp_ifm.push_back(i);
        for (int it = 0; it <= f; it++) begin
            for (int j = 0; j <= p; j++) begin
                int a = (it * (p + 1) + j) % 256;
                exp_ips_addr.push_back(a);
                exp_ips_data.push_back(en ? ipsum_rf[a] : 32'd0);
                exp_op_addr.push_back(a);
                exp_op_data.push_back(golden(p, it, j, en));
            end
        end
    endtask

    task automatic run_pass(int p, int f, int q, bit en, bit stall, bit hold, bit check_len);
        int d0;
        bit seen = 0;
        push_expect(p, f, q, en);
        stall_en    = stall;
        d0          = done_cnt;
        busy_cycles = 0;
        cfg_p = 2'(p); cfg_F = 5'(f); cfg_q = 2'(q); ipsum_en = en;
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            if (done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("[TB] FAIL pass_timeout got=no_done want=done p=%0d F=%0d", p, f);
        end
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL idle_after_done got=%b want=0", busy);
        end
        repeat (4) @(negedge clk);
        stall_en = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || done_cnt - d0 != 1) begin
            tests_failed++;
            $display("[TB] FAIL single_done got=busy%b/%0d want=busy0/1", busy, done_cnt - d0);
        end
        tests_run++;
        if (exp_filt.size() + exp_ifm.size() + exp_ips_addr.size() + exp_op_addr.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL leftover got=%0d/%0d/%0d/%0d want=0/0/0/0",
                     exp_filt.size(), exp_ifm.size(), exp_ips_addr.size(), exp_op_addr.size());
        end
        for (int it = 0; it <= f; it++) begin
            for (int j = 0; j <= p; j++) begin
                int a = (it * (p + 1) + j) % 256;
                tests_run++;
                if (opsum_rf[a] !== golden(p, it, j, en)) begin
                    tests_failed++;
                    $display("[TB] FAIL opsum_rf[%0d] got=%h want=%h", a, opsum_rf[a], golden(p, it, j, en));
                end
            end
        end
        if (check_len) begin
            int want = 2 + 3 * (p + 1) + (f + 3) + 2 * (p + 1) * (f + 1);
            tests_run++;
            if (busy_cycles != want) begin
                tests_failed++;
                $display("[TB] FAIL pass_length got=%0d want=%0d", busy_cycles, want);
            end
        end
        exp_filt.delete(); exp_ifm.delete(); exp_ips_addr.delete();
        exp_ips_data.delete(); exp_op_addr.delete(); exp_op_data.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b1; cfg_p = 2'd3; cfg_F = 5'd7; cfg_q = 2'd1; ipsum_en = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_status got=%b%b want=00", busy, done);
        end
        tests_run++;
        if (pe_if.PE_en !== 1'b0 || pe_if.i_config !== 9'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_config got=%b/%h want=0/000", pe_if.PE_en, pe_if.i_config);
        end
        tests_run++;
        if ({pe_if.filter_valid, pe_if.ifmap_valid, pe_if.ipsum_valid, pe_if.opsum_ready, opsum_we} !== 5'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_handshake got=%b%b%b%b%b want=00000", pe_if.filter_valid,
                     pe_if.ifmap_valid, pe_if.ipsum_valid, pe_if.opsum_ready, opsum_we);
        end
        tests_run++;
        if ({filt_addr, ifmap_addr, ipsum_addr, opsum_addr} !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_addr got=%h want=00000000", {filt_addr, ifmap_addr, ipsum_addr, opsum_addr});
        end
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        load_rfs();
        ipsum_rf[0] = 32'd5;
        run_pass(0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_no_ipsum();
        load_rfs();
        run_pass(3, 2, 3, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_stalls();
        load_rfs();
        run_pass(1, 4, 2, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_start_held();
        load_rfs();
        run_pass(1, 1, 0, 1'b1, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid();
        int writes = 0;
        load_rfs();
        push_expect(2, 3, 1, 1'b1);
        cfg_p = 2'd2; cfg_F = 5'd3; cfg_q = 2'd1; ipsum_en = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            if (opsum_we) begin
                writes++;
                if (writes == 4) break;
            end
            @(negedge clk);
        end
        tests_run++;
        if (writes != 4) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_reach got=%0d want=4", writes);
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || opsum_we !== 1'b0 || pe_if.opsum_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_stop got=%b%b%b want=000", busy, opsum_we, pe_if.opsum_ready);
        end
        tests_run++;
        if (pe_if.i_config !== 9'd0 || opsum_addr !== 8'd0 || pe_if.ipsum_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_clear got=%h/%0d/%b want=000/0/0", pe_if.i_config, opsum_addr, pe_if.ipsum_valid);
        end
        @(negedge clk);
        exp_filt.delete(); exp_ifm.delete(); exp_ips_addr.delete();
        exp_ips_data.delete(); exp_op_addr.delete(); exp_op_data.delete();
        rst = 1'b1;
        @(negedge clk);
        load_rfs();
        run_pass(2, 3, 1, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_max();
        load_rfs();
        run_pass(3, 31, 1, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; cfg_p = '0; cfg_F = '0; cfg_q = '0; ipsum_en = 1'b0;
        test_reset();
        test_single();
        test_no_ipsum();
        test_stalls();
        test_start_held();
        test_reset_mid();
        test_max();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pe_pass_ctrl.md
# pe_pass_ctrl

Sequencer that runs one complete processing pass of a single PE: it configures the PE, streams filter rows, ifmap words and input partial sums from local register-file buffers, and writes the returned output partial sums back. It sits between the PE and the global-buffer-side register files. It hides the PE's phase ordering (filter → ifmap → calc → ipsum → opsum, repeated F+1 times) behind a start/done interface.

## Interface
- `DATA_BITS`, 32, PE word width (4 packed int8 lanes for ifmap/filter, one 32-bit psum for ipsum/opsum)
- `CONFIG_SIZE`, 9, PE config width, encoding {p[1:0], F[4:0], q[1:0]}
- `AW`, 8, buffer address width

- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-low
- `start` in 1: begin pass; sampled only in IDLE
- `cfg_p` in 2: output-channel count − 1
- `cfg_F` in 5: output-column count − 1
- `cfg_q` in 2: input-lane count − 1
- `ipsum_en` in 1: 1 = read ipsum buffer, 0 = feed zeros
- `busy` out 1: high outside IDLE
- `done` out 1: one-cycle pulse at pass end
- `filt_addr` out AW, `filt_rdata` in DATA_BITS: filter RF (combinational read)
- `ifmap_addr` out AW, `ifmap_rdata` in DATA_BITS: ifmap RF
- `ipsum_addr` out AW, `ipsum_rdata` in DATA_BITS: ipsum RF
- `opsum_addr` out AW, `opsum_wdata` out DATA_BITS, `opsum_we` out 1: opsum RF write port
- `PE_en` out 1, `i_config` out CONFIG_SIZE: PE start/config
- `filter` out DATA_BITS, `filter_valid` out 1, `filter_ready` in 1
- `ifmap` out DATA_BITS, `ifmap_valid` out 1, `ifmap_ready` in 1
- `ipsum` out DATA_BITS, `ipsum_valid` out 1, `ipsum_ready` in 1
- `opsum` in DATA_BITS, `opsum_valid` in 1, `opsum_ready` out 1

## Operation
- Config (p,F,q,ipsum_en) latched on accepted `start`; held constant for the whole pass.
- States: IDLE, CONFIG, FILTER, IFMAP, IPSUM, OPSUM, DONE.
- IDLE: all outputs 0. `start` → CONFIG.
- CONFIG (1 cycle): `PE_en`=1, `i_config`={p,F,q}; → FILTER. `i_config` holds latched value in all non-IDLE states.
- FILTER: `filter_valid`=1, `filter`=`filt_rdata`, `filt_addr`=word count k. Transfer on valid&&ready. After 3(p+1) transfers → IFMAP, iteration it=0.
- IFMAP: `ifmap_valid`=1, `ifmap`=`ifmap_rdata` (raw; the PE applies its own offset), `ifmap_addr`=running ifmap count (never reset within a pass). Words per iteration: 3 when it=0, 1 otherwise. Total over pass = F+3. After last → IPSUM.
- IPSUM: `ipsum_valid`=1 held while PE computes (PE raises `ipsum_ready` only after calc); `ipsum`=`ipsum_rdata` if ipsum_en else 0; `ipsum_addr`=it·(p+1)+j, j=0..p. After p+1 transfers → OPSUM.
- OPSUM: `opsum_ready`=1; on `opsum_valid`: `opsum_we`=1, `opsum_wdata`=`opsum`, `opsum_addr`=it·(p+1)+j. After p+1 writes: it==F → DONE, else it++ → IFMAP.
- DONE (1 cycle): `done`=1; → IDLE.
- Address arithmetic truncated to AW bits (wraps modulo 2^AW; caller sizes buffers).

## Timing
- Reset (rst=0 at clk edge): state IDLE, all counters 0, every output 0 including `i_config`. Mid-pass reset aborts immediately, no further writes; PE must be reset with it.
- Valids are Moore outputs of state; data/address outputs combinational from counters and RF read data, so each transfer costs exactly one cycle with ready high.
- Counters advance only on handshake; ready low stalls with data/address stable.
- `opsum_we` is combinational = (state==OPSUM)&&`opsum_valid`; exactly one write per PE opsum transfer.
- Phase transition occurs on the clock edge of the final transfer; next phase's valid asserts the following cycle.
- `start` while busy ignored. `start` in DONE cycle ignored.
- `busy` high from cycle after accepted `start` through DONE inclusive.
- Minimum pass length (all readies always high): 2 + 3(p+1) + (F+3) + 2(p+1)(F+1) cycles plus PE calc stalls.

## Test plan
- p=0,F=0,q=0, ipsum_en=1, filt RF 0..2 = A,B,C, ifmap 0..2, ipsum[0]=5, PE model returns 5+dot -> exactly 3 filter, 3 ifmap, 1 ipsum, 1 write to addr 0, `done` once.
- p=3,F=2,q=3, ipsum_en=0 -> 12 filter reads addr 0..11, ifmap addr 0..4 in order (3,1,1 per iteration), ipsum value 0, opsum writes addr 0..11 in order.
- Random ready deassertion on all PE handshakes, p=1,F=4 -> no duplicated/dropped words; addresses and data held stable during stalls; opsum RF matches golden model.
- `start` asserted continuously during a pass -> single pass, `done` one pulse, new pass only after returning to IDLE.
- Assert rst=0 in OPSUM mid-write of p=2,F=3 -> next cycle all outputs 0, no `opsum_we`; subsequent start runs full pass correctly.
- F=31,p=3 -> opsum addresses reach 127, ifmap 0..33, `done` after 32 iterations.
